result_collect: RTL and testbench



---
 rtl/result_collect_if.sv | 33 +++
 rtl/result_collect.sv | 185 ++++++++++++++++++
 tb/tb_result_collect.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/result_collect_if.sv
// Signal bundle between result_collect and its partition, column FIFO and C2H stream neighbours.
// master = the collector, slave = the surrounding logic.
interface result_collect_if #(
    parameter int unsigned DATA_WIDTH   = 128,
    parameter int unsigned COL_MAX_SIZE = 4
);
    localparam int unsigned BYTE_BIT_ENABLE = DATA_WIDTH / 8;

    logic                               partition_done;
    logic [16*COL_MAX_SIZE-1:0]         col_beats;
    logic [DATA_WIDTH*COL_MAX_SIZE-1:0] data_fifo_dout;
    logic [COL_MAX_SIZE-1:0]            data_fifo_empty;
    logic [COL_MAX_SIZE-1:0]            data_fifo_rd_en;
    logic [DATA_WIDTH-1:0]              m_axis_c2h_tdata;
    logic                               m_axis_c2h_tvalid;
    logic                               m_axis_c2h_tready;
    logic                               m_axis_c2h_tlast;
    logic [BYTE_BIT_ENABLE-1:0]         m_axis_c2h_tkeep;
    logic                               process_done;
    logic                               err_residue;

    modport master (
        input  partition_done, col_beats, data_fifo_dout, data_fifo_empty, m_axis_c2h_tready,
        output data_fifo_rd_en, m_axis_c2h_tdata, m_axis_c2h_tvalid, m_axis_c2h_tlast,
               m_axis_c2h_tkeep, process_done, err_residue
    );

    modport slave (
        output partition_done, col_beats, data_fifo_dout, data_fifo_empty, m_axis_c2h_tready,
        input  data_fifo_rd_en, m_axis_c2h_tdata, m_axis_c2h_tvalid, m_axis_c2h_tlast,
               m_axis_c2h_tkeep, process_done, err_residue
    );
endinterface

// File: rtl/result_collect.sv
// Drains the per-column FIFOs in column order after partition completes and emits one C2H
// packet (header beat + all column data beats), then pulses process_done.
module result_collect #(
    parameter int unsigned DATA_WIDTH   = 128,
    parameter int unsigned COL_MAX_SIZE = 4,
    parameter logic [15:0] MAGIC        = 16'h5A5A
) (
    input  logic             user_clk,
    input  logic             user_rst,
    result_collect_if.master bus
);
    localparam int unsigned KEEP_W = DATA_WIDTH / 8;
    localparam int unsigned COL_W  = (COL_MAX_SIZE > 1) ? $clog2(COL_MAX_SIZE) : 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SETTLE    = 3'd1,
        HEADER    = 3'd2,
        DRAIN     = 3'd3,
        WAIT_LAST = 3'd4
    } state_e;

    state_e                              state_q, state_d;
    logic                                settle_q, settle_d;
    logic [COL_MAX_SIZE-1:0][15:0]       beats_q, beats_d;
    logic [31:0]                         total_q, total_d;
    logic [15:0]                         job_q, job_d;
    logic [COL_W-1:0]                    col_q, col_d;
    logic [15:0]                         rem_q, rem_d;
    logic [DATA_WIDTH-1:0]               tdata_q, tdata_d;
    logic                                tvalid_q, tvalid_d;
    logic                                tlast_q, tlast_d;
    logic                                done_q, done_d;
    logic                                err_q, err_d;

    logic [COL_MAX_SIZE-1:0][15:0]       col_beats_c;
    logic [COL_MAX_SIZE-1:0][DATA_WIDTH-1:0] dout_c;
    logic [31:0]                         sum_c;
    logic [COL_W-1:0]                    first_nz_c, next_nz_c, last_nz_c;
    logic [DATA_WIDTH-1:0]               header_c;
    logic                                load_ok_c;
    logic                                pop_c;
    logic [COL_MAX_SIZE-1:0]             rd_en_c;

    assign col_beats_c = bus.col_beats;
    assign dout_c      = bus.data_fifo_dout;

    // Column scan: job total, first/last non-empty column and the next non-empty one after col_q
    always_comb begin
        sum_c      = '0;
        first_nz_c = '0;
        next_nz_c  = '0;
        last_nz_c  = '0;
        for (int i = int'(COL_MAX_SIZE) - 1; i >= 0; i--) begin
            if (beats_q[i] != 16'd0) begin
                first_nz_c = COL_W'(i);
                if (i > int'(col_q)) next_nz_c = COL_W'(i);
            end
        end
        for (int i = 0; i < int'(COL_MAX_SIZE); i++) begin
            sum_c = sum_c + 32'(col_beats_c[i]);
            if (beats_q[i] != 16'd0) last_nz_c = COL_W'(i);
        end
    end

    always_comb begin
        header_c = '0;
        header_c[DATA_WIDTH-1 -: 16]  = MAGIC;
        header_c[DATA_WIDTH-17 -: 16] = job_q;
        for (int i = 0; i < int'(COL_MAX_SIZE); i++) begin
            header_c[32+16*i +: 16] = beats_q[i];
        end
        header_c[31:0] = total_q;
    end

    // Next state and output-stage load
    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        beats_d   = beats_q;
        total_d   = total_q;
        job_d     = job_q;
        col_d     = col_q;
        rem_d     = rem_q;
        tdata_d   = tdata_q;
        tlast_d   = tlast_q;
        tvalid_d  = tvalid_q & ~bus.m_axis_c2h_tready;
        done_d    = 1'b0;
        err_d     = err_q;
        rd_en_c   = '0;
        pop_c     = 1'b0;
        load_ok_c = ~tvalid_q | bus.m_axis_c2h_tready;

        case (state_q)
            IDLE: begin
                if (bus.partition_done) begin
                    beats_d  = col_beats_c;
                    total_d  = sum_c;
                    settle_d = 1'b0;
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                settle_d = 1'b1;
                if (settle_q) state_d = HEADER;
            end
            HEADER: begin
                if (load_ok_c) begin
                    tdata_d  = header_c;
                    tvalid_d = 1'b1;
                    tlast_d  = (total_q == 32'd0);
                    col_d    = first_nz_c;
                    rem_d    = beats_q[first_nz_c];
                    state_d  = (total_q == 32'd0) ? WAIT_LAST : DRAIN;
                end
            end
            DRAIN: begin
                // An empty FIFO just lets the output stage run dry; it is a stall, not an error
                pop_c = load_ok_c & ~bus.data_fifo_empty[col_q] & (rem_q != 16'd0);
                if (pop_c) begin
                    rd_en_c[col_q] = 1'b1;
                    tdata_d        = dout_c[col_q];
                    tvalid_d       = 1'b1;
                    tlast_d        = (rem_q == 16'd1) && (col_q == last_nz_c);
                    rem_d          = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        if (col_q == last_nz_c) begin
                            state_d = WAIT_LAST;
                        end else begin
                            col_d = next_nz_c;
                            rem_d = beats_q[next_nz_c];
                        end
                    end
                end
            end
            WAIT_LAST: begin
                if (tvalid_q && bus.m_axis_c2h_tready && tlast_q) begin
                    done_d  = 1'b1;
                    job_d   = job_q + 16'd1;
                    err_d   = err_q | ~(&bus.data_fifo_empty);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            state_q  <= IDLE;
            settle_q <= 1'b0;
            beats_q  <= '0;
            total_q  <= '0;
            job_q    <= '0;
            col_q    <= '0;
            rem_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            beats_q  <= beats_d;
            total_q  <= total_d;
            job_q    <= job_d;
            col_q    <= col_d;
            rem_q    <= rem_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign bus.data_fifo_rd_en   = rd_en_c;
    assign bus.m_axis_c2h_tdata  = tdata_q;
    assign bus.m_axis_c2h_tvalid = tvalid_q;
    assign bus.m_axis_c2h_tlast  = tlast_q;
    assign bus.m_axis_c2h_tkeep  = {KEEP_W{tvalid_q}};
    assign bus.process_done      = done_q;
    assign bus.err_residue       = err_q;
endmodule

// File: tb/tb_result_collect.sv
// Bench for result_collect: FWFT FIFO models, stream monitor, directed table, reset abort and
// randomized jobs checked against a packet-level reference model.
module tb_result_collect;
    localparam int unsigned DW = 128;
    localparam int unsigned NC = 4;
    localparam int unsigned NV = 6;

    typedef logic [DW-1:0]       word_t;
    typedef logic [NC-1:0][15:0] beats_t;
    typedef logic [NC-1:0][7:0]  extra_t;

    typedef struct {
        beats_t beats;
        extra_t extra;
        int     mode;
        bit     gap;
        bit     inject;
        int     exp_total;
        bit     exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    result_collect_if #(.DATA_WIDTH(DW), .COL_MAX_SIZE(NC)) bus ();

    result_collect #(.DATA_WIDTH(DW), .COL_MAX_SIZE(NC), .MAGIC(16'h5A5A)) dut (
        .user_clk (clk),
        .user_rst (rst),
        .bus      (bus)
    );

    word_t         fifo [NC][$];
    int            hide [NC];
    int            rdy_mode;
    int            cyc;
    logic [NC-1:0] taken;
    logic [15:0]   m_job;
    bit            m_err;
    int            n_tests;
    int            n_fail;

    word_t cap_data [$];
    bit    cap_last [$];
    int    pops [NC];
    int    viol, bubbles, done_cnt, done_cyc, last_acc_cyc, first_valid_cyc;
    bit    held_valid;
    word_t held_data;
    logic  held_last;

    vec_t tbl [NV];

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_w(input string name, input word_t act, input word_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_fifo();
        for (int i = 0; i < int'(NC); i++) begin
            bus.data_fifo_empty[i]        = (fifo[i].size() == 0) || (hide[i] > 0);
            bus.data_fifo_dout[DW*i +: DW] = (fifo[i].size() != 0) ? fifo[i][0] : '0;
        end
    endtask

    task automatic clear_mon();
        cap_data.delete();
        cap_last.delete();
        for (int i = 0; i < int'(NC); i++) pops[i] = 0;
        viol = 0; bubbles = 0; done_cnt = 0;
        done_cyc = -1; last_acc_cyc = -1; first_valid_cyc = -1;
        held_valid = 1'b0;
    endtask

    // FIFO pops and tready pattern, applied just after each rising edge
    always @(posedge clk) begin
        cyc++;
        taken = bus.data_fifo_rd_en;
        #1;
        for (int i = 0; i < int'(NC); i++) begin
            if (taken[i] && fifo[i].size() != 0) void'(fifo[i].pop_front());
            if (hide[i] > 0) hide[i]--;
        end
        case (rdy_mode)
            0:       bus.m_axis_c2h_tready = 1'b1;
            1:       bus.m_axis_c2h_tready = ~bus.m_axis_c2h_tready;
            default: bus.m_axis_c2h_tready = ($urandom_range(0, 3) != 0);
        endcase
        drive_fifo();
    end

    // Stream / FIFO-side monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.data_fifo_rd_en != '0) begin
                if (!$onehot(bus.data_fifo_rd_en)) viol++;
                if (bus.m_axis_c2h_tvalid && !bus.m_axis_c2h_tready) viol++;
                for (int i = 0; i < int'(NC); i++) begin
                    if (bus.data_fifo_rd_en[i]) begin
                        pops[i]++;
                        if (bus.data_fifo_empty[i]) viol++;
                    end
                end
            end
            if (held_valid && (!bus.m_axis_c2h_tvalid || bus.m_axis_c2h_tdata !== held_data ||
                               bus.m_axis_c2h_tlast !== held_last)) viol++;
            held_valid = bus.m_axis_c2h_tvalid && !bus.m_axis_c2h_tready;
            held_data  = bus.m_axis_c2h_tdata;
            held_last  = bus.m_axis_c2h_tlast;
            if (bus.m_axis_c2h_tvalid && bus.m_axis_c2h_tkeep !== '1) viol++;
            if (bus.m_axis_c2h_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (first_valid_cyc >= 0 && last_acc_cyc < 0 && !bus.m_axis_c2h_tvalid) bubbles++;
            if (bus.m_axis_c2h_tvalid && bus.m_axis_c2h_tready) begin
                cap_data.push_back(bus.m_axis_c2h_tdata);
                cap_last.push_back(bus.m_axis_c2h_tlast);
                if (bus.m_axis_c2h_tlast) last_acc_cyc = cyc;
            end
            if (bus.process_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic set_vec(input int idx, input int b0, input int b1, input int b2, input int b3,
                           input int e0, input int mode, input bit gap, input bit inject,
                           input int exp_total, input bit exp_err);
        tbl[idx].beats     = {16'(b3), 16'(b2), 16'(b1), 16'(b0)};
        tbl[idx].extra     = {8'd0, 8'd0, 8'd0, 8'(e0)};
        tbl[idx].mode      = mode;
        tbl[idx].gap       = gap;
        tbl[idx].inject    = inject;
        tbl[idx].exp_total = exp_total;
        tbl[idx].exp_err   = exp_err;
    endtask

    // One job: preload FIFOs, build the expected packet, pulse partition_done, check the result
    task automatic run_job(input beats_t b, input extra_t extra, input int mode, input bit gap,
                           input bit inject, input bit rnd_hide, input string tag,
                           output word_t got_hdr);
        word_t  exp_q [$];
        word_t  hdr;
        int     total;
        int     pd_cyc;
        int     errs;
        bit     exp_res;
        bit     allow_hide;
        bit     injected;
        bit     gapped;
        beats_t pop_vec;

        rdy_mode = mode;
        for (int c = 0; c < int'(NC); c++) begin
            for (int k = 0; k < int'(b[c]) + int'(extra[c]); k++)
                fifo[c].push_back({$urandom, $urandom, $urandom, $urandom});
        end
        drive_fifo();

        total = 0;
        for (int c = 0; c < int'(NC); c++) total += int'(b[c]);
        hdr = '0;
        hdr[127:112] = 16'h5A5A;
        hdr[111:96]  = m_job;
        for (int c = 0; c < int'(NC); c++) hdr[32+16*c +: 16] = b[c];
        hdr[31:0] = 32'(total);
        exp_q.push_back(hdr);
        exp_res = 1'b0;
        for (int c = 0; c < int'(NC); c++) begin
            for (int k = 0; k < int'(b[c]); k++) exp_q.push_back(fifo[c][k]);
            if (fifo[c].size() > int'(b[c])) exp_res = 1'b1;
        end
        // Hidden flags could mask a real residue at job end, so only hide when that cannot matter
        allow_hide = rnd_hide && (!exp_res || m_err);
        m_err = m_err | exp_res;

        clear_mon();
        @(negedge clk);
        bus.col_beats      = b;
        bus.partition_done = 1'b1;
        pd_cyc             = cyc;
        @(negedge clk);
        bus.partition_done = 1'b0;
        bus.col_beats      = {$urandom, $urandom};

        injected = 1'b0;
        gapped   = 1'b0;
        for (int t = 0; t < 3000 && done_cnt == 0; t++) begin
            @(negedge clk);
            bus.partition_done = 1'b0;
            if (inject && !injected && cap_data.size() >= 2) begin
                bus.partition_done = 1'b1;
                injected = 1'b1;
            end
            if (gap && !gapped && cap_data.size() >= 2) begin
                hide[0] = 5;
                gapped  = 1'b1;
                drive_fifo();
            end
            if (allow_hide && $urandom_range(0, 7) == 0) begin
                hide[$urandom_range(0, NC-1)] = $urandom_range(1, 4);
                drive_fifo();
            end
        end
        bus.partition_done = 1'b0;
        repeat (10) @(negedge clk);

        check_int({tag, " done_count"}, done_cnt, 1);
        check_int({tag, " pkt_len"}, cap_data.size(), exp_q.size());
        errs = 0;
        for (int k = 0; k < cap_data.size() && k < exp_q.size(); k++) begin
            if (cap_data[k] !== exp_q[k]) errs++;
            if (cap_last[k] != (k == exp_q.size() - 1)) errs++;
        end
        check_int({tag, " beat_errors"}, errs, 0);
        check_int({tag, " hdr_latency"}, first_valid_cyc - pd_cyc, 4);
        check_int({tag, " done_delay"}, done_cyc - last_acc_cyc, 1);
        for (int c = 0; c < int'(NC); c++) pop_vec[c] = 16'(pops[c]);
        check_w({tag, " pops"}, DW'(pop_vec), DW'(b));
        check_int({tag, " protocol"}, viol, 0);
        check_w({tag, " idle_tvalid"}, DW'(bus.m_axis_c2h_tvalid), '0);
        check_w({tag, " err_residue"}, DW'(bus.err_residue), DW'(m_err));
        if (gap) check_int({tag, " gap_bubble"}, int'(bubbles > 0), 1);
        else if (!allow_hide) check_int({tag, " bubbles"}, bubbles, 0);

        got_hdr = (cap_data.size() != 0) ? cap_data[0] : '0;
        m_job   = m_job + 16'd1;
    endtask

    initial begin
        word_t  hdr;
        beats_t rb;
        extra_t re;

        n_tests = 0; n_fail = 0; cyc = 0;
        m_job = '0; m_err = 1'b0; rdy_mode = 0;
        rst = 1'b1;
        bus.partition_done    = 1'b0;
        bus.col_beats         = '0;
        bus.m_axis_c2h_tready = 1'b1;
        for (int i = 0; i < int'(NC); i++) hide[i] = 0;
        drive_fifo();
        clear_mon();

        //              b0 b1 b2 b3 e0 mode gap inj total err
        set_vec(0,      3, 0, 2, 1, 0, 0,   0,  0,  6,    0);
        set_vec(1,      0, 0, 0, 0, 0, 0,   0,  0,  0,    0);
        set_vec(2,      3, 0, 2, 1, 0, 1,   0,  0,  6,    0);
        set_vec(3,      5, 1, 0, 2, 0, 0,   1,  0,  8,    0);
        set_vec(4,      1, 2, 3, 4, 0, 0,   0,  1,  10,   0);
        set_vec(5,      1, 0, 0, 0, 1, 0,   0,  0,  1,    1);

        repeat (3) @(negedge clk);
        check_w("rst tvalid", DW'(bus.m_axis_c2h_tvalid), '0);
        check_w("rst tlast",  DW'(bus.m_axis_c2h_tlast), '0);
        check_w("rst tdata",  bus.m_axis_c2h_tdata, '0);
        check_w("rst tkeep",  DW'(bus.m_axis_c2h_tkeep), '0);
        check_w("rst done",   DW'(bus.process_done), '0);
        check_w("rst err",    DW'(bus.err_residue), '0);
        check_w("rst rd_en",  DW'(bus.data_fifo_rd_en), '0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < int'(NV); i++) begin
            run_job(tbl[i].beats, tbl[i].extra, tbl[i].mode, tbl[i].gap, tbl[i].inject, 1'b0,
                    $sformatf("vec%0d", i), hdr);
            check_int($sformatf("vec%0d hdr_total", i), int'(hdr[31:0]), tbl[i].exp_total);
            check_int($sformatf("vec%0d hdr_job", i), int'(hdr[111:96]), i);
            check_w($sformatf("vec%0d err", i), DW'(bus.err_residue), DW'(tbl[i].exp_err));
        end

        // Asynchronous reset in the middle of DRAIN
        clear_mon();
        rdy_mode = 0;
        for (int c = 0; c < int'(NC); c++) begin
            repeat (8) fifo[c].push_back({$urandom, $urandom, $urandom, $urandom});
        end
        drive_fifo();
        @(negedge clk);
        bus.col_beats      = {16'd8, 16'd8, 16'd8, 16'd8};
        bus.partition_done = 1'b1;
        @(negedge clk);
        bus.partition_done = 1'b0;
        for (int t = 0; t < 200 && cap_data.size() < 4; t++) @(negedge clk);
        check_int("abort reached_drain", int'(cap_data.size() >= 4), 1);
        #2 rst = 1'b1;
        #1;
        check_w("abort tvalid", DW'(bus.m_axis_c2h_tvalid), '0);
        check_w("abort err",    DW'(bus.err_residue), '0);
        check_w("abort done",   DW'(bus.process_done), '0);
        check_w("abort rd_en",  DW'(bus.data_fifo_rd_en), '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < int'(NC); c++) begin
            fifo[c].delete();
            hide[c] = 0;
        end
        drive_fifo();
        m_job = '0;
        m_err = 1'b0;
        @(negedge clk);
        run_job({16'd1, 16'd0, 16'd3, 16'd0}, '0, 0, 1'b0, 1'b0, 1'b0, "post_rst", hdr);
        check_int("post_rst hdr_job", int'(hdr[111:96]), 0);

        // Randomized jobs against the packet model
        for (int r = 0; r < 25; r++) begin
            for (int c = 0; c < int'(NC); c++) begin
                rb[c] = 16'($urandom_range(0, 5));
                re[c] = ($urandom_range(0, 9) == 0) ? 8'd1 : 8'd0;
            end
            run_job(rb, re, 2, 1'b0, 1'b0, 1'b1, $sformatf("rnd%0d", r), hdr);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
